fir_op_scheduler: RTL and testbench
===================================

// Module: fir_op_scheduler
// PURPOSE
//  Sequences the FIR filter's op/data input bus (fir_ui -> filter ui_in). Arbitrates
//  between a buffered sample stream and a coefficient/mode config requester, and
//  provides a delay-line flush. The bus is never left idle at op 00, because every
//  op-00 cycle shifts the delay line. Idle cycles instead rewrite h0 with its own
//  shadowed value, which leaves the filter state unchanged.
// PARAMETERS
//  SMP_DEPTH   4  sample FIFO depth; must be a power of 2 and at least 2
//  MAX_CFG_RUN 3  maximum consecutive config grants while a sample is waiting
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   reset, asynchronous, active-low
//  s_valid     in   1   sample request
//  s_data      in   6   sample value (unsigned)
//  s_ready     out  1   FIFO can accept; equals !full
//  cfg_valid   in   1   config request
//  cfg_op      in   2   01=h0, 10=h1, 11=mode/h2h3 (same encoding as ui_in[7:6])
//  cfg_data    in   6   config payload (same encoding as ui_in[5:0])
//  cfg_ready   out  1   config granted this cycle (combinational)
//  cfg_err     out  1   1-cycle pulse: cfg_op==00 accepted and dropped
//  flush_req   in   1   level; starts a flush when the block is in RUN
//  flush_busy  out  1   high while in FLUSH
//  fir_ui      out  8   registered bus {op[1:0],data[5:0]}; drives filter ui_in
//  y_valid     out  1   filter uo_out holds a result from 4 real samples
//  h0_shadow   out  6   scheduler's copy of h0[5:0]
//  sample_cnt  out  16  wrapping count of real samples issued (flush zeros excluded)
//  fifo_level  out  $clog2(SMP_DEPTH)+1  sample FIFO occupancy
// BEHAVIOUR
//  Reset values: fir_ui=8'h41, h0_shadow=1, y_valid=0, sample_cnt=0, fifo empty,
//   flush_busy=0, cfg_err=0, cfg_streak=0, state=RUN.
//  FSM has two states. RUN: arbitrate every cycle. FLUSH: issue 4 cycles of op 00,
//   data 0, then return to RUN.
//  Transition: RUN->FLUSH when flush_req=1. flush_req has top priority; no config or
//   sample is granted that cycle. The first zero sample appears on fir_ui at the next edge.
//  In FLUSH: 2-bit counter; flush_req ignored; cfg_ready=0; FIFO keeps its contents;
//   FIFO push still allowed.
//  RUN priority, evaluated each cycle:
//   1. flush.
//   2. sample, if the FIFO is non-empty and cfg_streak==MAX_CFG_RUN.
//   3. config, if cfg_valid.
//   4. sample, if the FIFO is non-empty.
//   5. Idle: fir_ui <= {2'b01, h0_shadow}.
//  Sample grant: pop FIFO head; fir_ui <= {2'b00, head}; sample_cnt+1 (wraps at 16'hFFFF).
//  Config grant: cfg_ready=1; fir_ui <= {cfg_op, cfg_data}.
//   If cfg_op==00: bus shows the idle refresh instead, and cfg_err pulses next cycle.
//  cfg_streak:
//   +1 on each config grant while the FIFO is non-empty; saturates at MAX_CFG_RUN.
//   Cleared on a sample grant or when the FIFO is empty.
//  h0_shadow update, at the edge where the op is loaded into fir_ui:
//   op01 -> cfg_data.
//   op11 with data[3]=1 -> per-mode preset: mode00=1, mode01=1, mode10=4, mode11=1.
//   op10, and op11 with data[3]=0, leave h0_shadow unchanged.
//  FIFO:
//   Push when s_valid & s_ready.
//   Push and pop in the same cycle is legal when not full; level stays the same.
//   A sample pushed into an empty FIFO can be granted no earlier than the next cycle.
//  y_valid:
//   Internal count n of op-00 bus cycles since reset or since FLUSH exit; saturates at 4.
//   Zero samples issued during FLUSH do not count.
//   y_valid rises 2 cycles after the edge that loads the 4th counted sample into
//    fir_ui (delay-line edge + output-register edge). Implement with a 2-stage shift.
//   Entering FLUSH clears n and y_valid immediately.
//  Asynchronous reset mid-flush or mid-burst: return to the reset values above. Any
//   in-flight handshake is lost; requesters must re-present it.
// TESTING
//  1. Reset, no traffic -> fir_ui=8'h41 every cycle; cfg_ready=0; y_valid=0.
//  2. Push samples 5,6,7,8 -> fir_ui shows 8'h05,06,07,08 on consecutive cycles;
//     y_valid=1 two cycles after 8'h08; sample_cnt=4.
//  3. cfg_valid held with op01/data 6'd9 -> cfg_ready=1; fir_ui=8'h49;
//     idle bus is 8'h49 afterwards; h0_shadow=9.
//  4. FIFO non-empty plus continuous cfg_valid, MAX_CFG_RUN=3 -> bus pattern is
//     cfg,cfg,cfg,sample, repeating; no sample starves.
//  5. flush_req during streaming -> 4 cycles of 8'h00; flush_busy=1 for those 4;
//     y_valid=0; sample_cnt unchanged; FIFO data resumes intact.
//  6. Mode preset op11 data 6'b10_1000 -> fir_ui=8'hE8; h0_shadow=4; idle bus 8'h44.
//     cfg_op=00 -> cfg_err pulse; idle bus shown for that grant.

Source files
------------

// File: rtl/fir_op_scheduler.sv
// Drives the FIR filter's ui_in bus: arbitrates buffered samples against config writes,
// runs 4-cycle delay-line flushes, and never idles at op 00 (idle rewrites h0 with itself).
module fir_op_scheduler #(
   parameter int SMP_DEPTH   = 4,
   parameter int MAX_CFG_RUN = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_valid,
   input  logic [5:0]                   s_data,
   output logic                         s_ready,
   input  logic                         cfg_valid,
   input  logic [1:0]                   cfg_op,
   input  logic [5:0]                   cfg_data,
   output logic                         cfg_ready,
   output logic                         cfg_err,
   input  logic                         flush_req,
   output logic                         flush_busy,
   output logic [7:0]                   fir_ui,
   output logic                         y_valid,
   output logic [5:0]                   h0_shadow,
   output logic [15:0]                  sample_cnt,
   output logic [$clog2(SMP_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(SMP_DEPTH);
   localparam int SW = $clog2(MAX_CFG_RUN + 1);
   localparam logic [AW:0]   PTR_ONE    = (AW+1)'(1);
   localparam logic [AW:0]   DEPTH_L    = (AW+1)'(SMP_DEPTH);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CFG_RUN);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t      state;
   logic [1:0]  flush_cnt;
   logic [SW-1:0] cfg_streak;
   logic [2:0]  n_cnt;
   logic [1:0]  y_sh;
   logic [AW:0] wr_ptr, rd_ptr;
   logic [5:0]  mem [SMP_DEPTH];

   logic       empty, full, push;
   logic       in_run, flush_go, smp_pri, cfg_go, smp_go;
   logic [5:0] head;
   logic [7:0] idle_word;

   function automatic logic [5:0] mode_preset(input logic [1:0] mode);
      return (mode == 2'b10) ? 6'd4 : 6'd1;
   endfunction

   assign fifo_level = wr_ptr - rd_ptr;
   assign empty      = (fifo_level == '0);
   assign full       = (fifo_level == DEPTH_L);
   assign s_ready    = !full;
   assign push       = s_valid && s_ready;
   assign head       = mem[rd_ptr[AW-1:0]];
   assign idle_word  = {2'b01, h0_shadow};

   // Arbitration: flush, starved sample, config, sample, idle refresh.
   assign in_run   = (state == RUN);
   assign flush_go = in_run && flush_req;
   assign smp_pri  = in_run && !flush_req && !empty && (cfg_streak == STREAK_MAX);
   assign cfg_go   = in_run && !flush_req && !smp_pri && cfg_valid;
   assign smp_go   = in_run && !flush_req && !empty && !cfg_go;

   assign cfg_ready  = cfg_go;
   assign flush_busy = (state == FLUSH);
   assign y_valid    = y_sh[1];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         flush_cnt  <= 2'd0;
         fir_ui     <= 8'h41;
         h0_shadow  <= 6'd1;
         cfg_streak <= '0;
         sample_cnt <= 16'd0;
         n_cnt      <= 3'd0;
         y_sh       <= 2'b00;
         cfg_err    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PTR_ONE;
         if (smp_go) rd_ptr <= rd_ptr + PTR_ONE;

         cfg_err <= cfg_go && (cfg_op == 2'b00);

         if (empty || smp_go)
            cfg_streak <= '0;
         else if (cfg_go && (cfg_streak != STREAK_MAX))
            cfg_streak <= cfg_streak + SW'(1);

         case (state)
            RUN: begin
               if (flush_go) begin
                  state     <= FLUSH;
                  flush_cnt <= 2'd0;
                  fir_ui    <= 8'h00;
                  n_cnt     <= 3'd0;
                  y_sh      <= 2'b00;
               end else begin
                  y_sh <= {y_sh[0], (n_cnt == 3'd4)};
                  if (smp_go) begin
                     fir_ui     <= {2'b00, head};
                     sample_cnt <= sample_cnt + 16'd1;
                     if (n_cnt != 3'd4) n_cnt <= n_cnt + 3'd1;
                  end else if (cfg_go) begin
                     // An op-00 config would shift the delay line; show the idle refresh instead.
                     fir_ui <= (cfg_op == 2'b00) ? idle_word : {cfg_op, cfg_data};
                     case (cfg_op)
                        2'b01:   h0_shadow <= cfg_data;
                        2'b11:   if (cfg_data[3]) h0_shadow <= mode_preset(cfg_data[5:4]);
                        default: ;
                     endcase
                  end else begin
                     fir_ui <= idle_word;
                  end
               end
            end
            FLUSH: begin
               flush_cnt <= flush_cnt + 2'd1;
               if (flush_cnt == 2'd3) begin
                  state  <= RUN;
                  fir_ui <= idle_word;
               end else begin
                  fir_ui <= 8'h00;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_op_scheduler.sv
// Bench for fir_op_scheduler: per-cycle vector table with a bus-word scoreboard,
// then hand sequences for mode presets, dropped op-00 config and reset mid-flush.
module tb_fir_op_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid, s_ready;
   logic [5:0]  s_data;
   logic        cfg_valid, cfg_ready, cfg_err;
   logic [1:0]  cfg_op;
   logic [5:0]  cfg_data;
   logic        flush_req, flush_busy;
   logic [7:0]  fir_ui;
   logic        y_valid;
   logic [5:0]  h0_shadow;
   logic [15:0] sample_cnt;
   logic [2:0]  fifo_level;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      logic        sv;
      logic [5:0]  sd;
      logic        cv;
      logic [1:0]  cop;
      logic [5:0]  cd;
      logic        fr;
      logic        rdy;
      logic [7:0]  ui;
      logic        yv;
      logic [15:0] cnt;
      logic [2:0]  lvl;
      logic        busy;
   } vec_t;

   vec_t vt[28];

   fir_op_scheduler #(.SMP_DEPTH(4), .MAX_CFG_RUN(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .cfg_valid(cfg_valid), .cfg_op(cfg_op), .cfg_data(cfg_data),
      .cfg_ready(cfg_ready), .cfg_err(cfg_err),
      .flush_req(flush_req), .flush_busy(flush_busy),
      .fir_ui(fir_ui), .y_valid(y_valid), .h0_shadow(h0_shadow),
      .sample_cnt(sample_cnt), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input int sv, input int sd, input int cv, input int cop,
                               input int cd, input int fr, input int rdy, input int ui,
                               input int yv, input int cnt, input int lvl, input int busy);
      vec_t v;
      v.sv = sv[0]; v.sd = sd[5:0]; v.cv = cv[0]; v.cop = cop[1:0]; v.cd = cd[5:0];
      v.fr = fr[0]; v.rdy = rdy[0]; v.ui = ui[7:0]; v.yv = yv[0]; v.cnt = cnt[15:0];
      v.lvl = lvl[2:0]; v.busy = busy[0];
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One bus cycle: drive at negedge, check the combinational grant, then the loaded bus word.
   task automatic bus_cycle(input string tag, input logic sv, input logic [5:0] sd,
                            input logic cv, input logic [1:0] cop, input logic [5:0] cd,
                            input logic fr, input logic exp_rdy, input logic [7:0] exp_ui);
      logic [7:0] e;
      @(negedge clk);
      s_valid = sv; s_data = sd; cfg_valid = cv; cfg_op = cop; cfg_data = cd; flush_req = fr;
      #1;
      check({tag, " cfg_ready"}, 16'(cfg_ready), 16'(exp_rdy));
      exp_q.push_back(exp_ui);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({tag, " fir_ui"}, 16'(fir_ui), 16'(e));
   endtask

   initial begin
      rst_n = 1'b0;
      s_valid = 0; s_data = 0; cfg_valid = 0; cfg_op = 0; cfg_data = 0; flush_req = 0;

      //          sv sd  cv op cd fr rdy  ui  yv cnt lvl busy
      vt[0]  = mk(0, 0,  0, 0, 0, 0, 0, 'h41, 0, 0, 0, 0);
      vt[1]  = mk(1, 5,  0, 0, 0, 0, 0, 'h41, 0, 0, 1, 0);
      vt[2]  = mk(1, 6,  0, 0, 0, 0, 0, 'h05, 0, 1, 1, 0);
      vt[3]  = mk(1, 7,  0, 0, 0, 0, 0, 'h06, 0, 2, 1, 0);
      vt[4]  = mk(1, 8,  0, 0, 0, 0, 0, 'h07, 0, 3, 1, 0);
      vt[5]  = mk(0, 0,  0, 0, 0, 0, 0, 'h08, 0, 4, 0, 0);
      vt[6]  = mk(0, 0,  0, 0, 0, 0, 0, 'h41, 0, 4, 0, 0);
      vt[7]  = mk(0, 0,  0, 0, 0, 0, 0, 'h41, 1, 4, 0, 0);
      vt[8]  = mk(0, 0,  1, 1, 9, 0, 1, 'h49, 1, 4, 0, 0);
      vt[9]  = mk(0, 0,  0, 0, 0, 0, 0, 'h49, 1, 4, 0, 0);
      vt[10] = mk(1, 10, 1, 1, 9, 0, 1, 'h49, 1, 4, 1, 0);
      vt[11] = mk(1, 11, 1, 1, 9, 0, 1, 'h49, 1, 4, 2, 0);
      vt[12] = mk(1, 12, 1, 1, 9, 0, 1, 'h49, 1, 4, 3, 0);
      vt[13] = mk(1, 13, 1, 1, 9, 0, 1, 'h49, 1, 4, 4, 0);
      vt[14] = mk(1, 14, 1, 1, 9, 0, 0, 'h0A, 1, 5, 3, 0);
      vt[15] = mk(0, 0,  1, 1, 9, 0, 1, 'h49, 1, 5, 3, 0);
      vt[16] = mk(0, 0,  1, 1, 9, 0, 1, 'h49, 1, 5, 3, 0);
      vt[17] = mk(0, 0,  1, 1, 9, 0, 1, 'h49, 1, 5, 3, 0);
      vt[18] = mk(0, 0,  1, 1, 9, 0, 0, 'h0B, 1, 6, 2, 0);
      vt[19] = mk(0, 0,  1, 1, 9, 1, 0, 'h00, 0, 6, 2, 1);
      vt[20] = mk(1, 15, 1, 1, 9, 1, 0, 'h00, 0, 6, 3, 1);
      vt[21] = mk(0, 0,  0, 0, 0, 0, 0, 'h00, 0, 6, 3, 1);
      vt[22] = mk(0, 0,  0, 0, 0, 0, 0, 'h00, 0, 6, 3, 1);
      vt[23] = mk(0, 0,  0, 0, 0, 0, 0, 'h49, 0, 6, 3, 0);
      vt[24] = mk(0, 0,  0, 0, 0, 0, 0, 'h0C, 0, 7, 2, 0);
      vt[25] = mk(0, 0,  0, 0, 0, 0, 0, 'h0D, 0, 8, 1, 0);
      vt[26] = mk(0, 0,  0, 0, 0, 0, 0, 'h0F, 0, 9, 0, 0);
      vt[27] = mk(0, 0,  0, 0, 0, 0, 0, 'h49, 0, 9, 0, 0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst fir_ui",     16'(fir_ui),     16'h0041);
      check("rst h0_shadow",  16'(h0_shadow),  16'd1);
      check("rst sample_cnt", sample_cnt,      16'd0);
      check("rst fifo_level", 16'(fifo_level), 16'd0);
      check("rst flush_busy", 16'(flush_busy), 16'd0);
      check("rst y_valid",    16'(y_valid),    16'd0);
      check("rst cfg_err",    16'(cfg_err),    16'd0);
      check("rst cfg_ready",  16'(cfg_ready),  16'd0);
      check("rst s_ready",    16'(s_ready),    16'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven cycles: streaming, config, starvation guard, flush
      for (int i = 0; i < 28; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         bus_cycle(tag, vt[i].sv, vt[i].sd, vt[i].cv, vt[i].cop, vt[i].cd, vt[i].fr,
                   vt[i].rdy, vt[i].ui);
         check({tag, " y_valid"},    16'(y_valid),    16'(vt[i].yv));
         check({tag, " sample_cnt"}, sample_cnt,      vt[i].cnt);
         check({tag, " fifo_level"}, 16'(fifo_level), 16'(vt[i].lvl));
         check({tag, " flush_busy"}, 16'(flush_busy), 16'(vt[i].busy));
      end
      check("h0 after op01", 16'(h0_shadow), 16'd9);

      // Mode presets, dropped op-00 config, non-preset writes
      bus_cycle("mode10 preset", 0, 0, 1, 2'b11, 6'b10_1000, 0, 1, 8'hE8);
      check("mode10 h0", 16'(h0_shadow), 16'd4);
      bus_cycle("idle after preset", 0, 0, 0, 0, 0, 0, 0, 8'h44);
      bus_cycle("op00 cfg", 0, 0, 1, 2'b00, 6'd5, 0, 1, 8'h44);
      check("op00 cfg_err pulse", 16'(cfg_err), 16'd1);
      check("op00 h0", 16'(h0_shadow), 16'd4);
      bus_cycle("after op00", 0, 0, 0, 0, 0, 0, 0, 8'h44);
      check("cfg_err cleared", 16'(cfg_err), 16'd0);
      bus_cycle("op11 no preset", 0, 0, 1, 2'b11, 6'b01_0000, 0, 1, 8'hD0);
      check("op11 no preset h0", 16'(h0_shadow), 16'd4);
      bus_cycle("op10 h1", 0, 0, 1, 2'b10, 6'd7, 0, 1, 8'h87);
      check("op10 h0", 16'(h0_shadow), 16'd4);
      bus_cycle("mode00 preset", 0, 0, 1, 2'b11, 6'b00_1000, 0, 1, 8'hC8);
      check("mode00 h0", 16'(h0_shadow), 16'd1);

      // Asynchronous reset in the middle of a flush
      bus_cycle("push before flush", 1, 6'd20, 0, 0, 0, 0, 0, 8'h41);
      bus_cycle("flush start", 0, 0, 0, 0, 0, 1, 0, 8'h00);
      check("flush busy", 16'(flush_busy), 16'd1);
      @(negedge clk);
      flush_req = 0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midflush rst fir_ui",     16'(fir_ui),     16'h0041);
      check("midflush rst flush_busy", 16'(flush_busy), 16'd0);
      check("midflush rst fifo_level", 16'(fifo_level), 16'd0);
      check("midflush rst sample_cnt", sample_cnt,      16'd0);
      check("midflush rst h0_shadow",  16'(h0_shadow),  16'd1);
      check("midflush rst y_valid",    16'(y_valid),    16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus_cycle("post reset idle", 0, 0, 0, 0, 0, 0, 0, 8'h41);
      check("scoreboard drained", 16'(exp_q.size()), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
